// File: rtl/bcrypt_pkg.sv
// Shared bcrypt constants and the ECB sequencer state type.
package bcrypt_pkg;

  localparam int BLOCK_W             = 64;
  localparam int HALF_W              = 32;
  localparam int BCRYPT_CTEXT_BLOCKS = 3;
  localparam int BCRYPT_ECB_PASSES   = 64;

  // Initial ctext buffer: the 24-byte magic string, byte 0 in the MSBs.
  localparam logic [BLOCK_W*BCRYPT_CTEXT_BLOCKS-1:0] BCRYPT_CTEXT_INIT =
    "OrpheanBeholderScryDoubt";

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/ecb_encrypt_ctrl.sv
// bcrypt final ECB stage: runs every buffer block through an external Blowfish
// encrypt core NUM_PASSES times, writing each result back in place.
module ecb_encrypt_ctrl
  import bcrypt_pkg::*;
#(
  parameter int NUM_BLOCKS = BCRYPT_CTEXT_BLOCKS,
  parameter int NUM_PASSES = BCRYPT_ECB_PASSES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [BLOCK_W*NUM_BLOCKS-1:0] ctext_in,
  output logic [BLOCK_W*NUM_BLOCKS-1:0] ctext_out,
  output logic                          busy,
  output logic                          done,
  output logic                          enc_valid,
  input  logic                          enc_ready,
  output logic [HALF_W-1:0]             enc_l,
  output logic [HALF_W-1:0]             enc_r,
  input  logic                          res_valid,
  input  logic [HALF_W-1:0]             res_l,
  input  logic [HALF_W-1:0]             res_r
);

  localparam int BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int PASS_W = $clog2(NUM_PASSES) + 1;

  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_t               state;
  logic [BLK_W-1:0]     blk;
  logic [PASS_W-1:0]    pass;
  logic [BLOCK_W-1:0]   blk_buf [NUM_BLOCKS];

  logic [BLOCK_W-1:0]   in_blk0;
  logic [BLOCK_W-1:0]   res_blk;
  logic [BLOCK_W-1:0]   nxt_data;
  logic [BLK_W-1:0]     blk_nxt;
  logic                 last_blk;
  logic                 last_job_blk;

  assign in_blk0 = ctext_in[BLOCK_W*NUM_BLOCKS-1 -: BLOCK_W];

  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_out
    assign ctext_out[BLOCK_W*(NUM_BLOCKS-b)-1 -: BLOCK_W] = blk_buf[b];
  end

  always_comb begin
    res_blk      = {res_l, res_r};
    last_blk     = (blk == LAST_BLK);
    last_job_blk = last_blk && (pass == LAST_PASS);
    blk_nxt      = last_blk ? '0 : blk + BLK_W'(1);
    // With a single block the next request is the result just received.
    nxt_data     = (blk_nxt == blk) ? res_blk : blk_buf[blk_nxt];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk       <= '0;
      pass      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      enc_valid <= 1'b0;
      enc_l     <= '0;
      enc_r     <= '0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        blk_buf[b] <= '0;
      end
    end else if (abort) begin
      // Buffer keeps whatever partial data it has; a late result is dropped in IDLE.
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      enc_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
              blk_buf[b] <= ctext_in[BLOCK_W*(NUM_BLOCKS-b)-1 -: BLOCK_W];
            end
            blk            <= '0;
            pass           <= '0;
            {enc_l, enc_r} <= in_blk0;
            enc_valid      <= 1'b1;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (enc_ready) begin
            enc_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (res_valid) begin
            blk_buf[blk] <= res_blk;
            blk          <= blk_nxt;
            if (last_blk) begin
              pass <= pass + PASS_W'(1);
            end
            if (last_job_blk) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              {enc_l, enc_r} <= nxt_data;
              enc_valid      <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecb_encrypt_ctrl.sv
// Randomized bench for ecb_encrypt_ctrl with a behavioural encrypt core and buffer model.
`timescale 1ns/1ps
module tb_ecb_encrypt_ctrl;
  import bcrypt_pkg::*;

  localparam int NB = 3;
  localparam int NP = 64;
  localparam int W  = 64 * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, enc_ready, res_valid;
  logic [W-1:0]  ctext_in, ctext_out, ctext_out1;
  logic          busy, done, enc_valid, busy1, done1, enc_valid1;
  logic [31:0]   enc_l, enc_r, enc_l1, enc_r1, res_l, res_r;

  ecb_encrypt_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ctext_in(ctext_in), .ctext_out(ctext_out),
    .busy(busy), .done(done), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_l(enc_l), .enc_r(enc_r),
    .res_valid(res_valid), .res_l(res_l), .res_r(res_r)
  );

  // Single-pass instance shares all inputs; only observed during the first job.
  ecb_encrypt_ctrl #(.NUM_BLOCKS(NB), .NUM_PASSES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ctext_in(ctext_in), .ctext_out(ctext_out1),
    .busy(busy1), .done(done1), .enc_valid(enc_valid1), .enc_ready(enc_ready),
    .enc_l(enc_l1), .enc_r(enc_r1),
    .res_valid(res_valid), .res_l(res_l), .res_r(res_r)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core behaviour: mode 0 is the plain XOR core, mode 1 a keyed Feistel stand-in.
  function automatic logic [63:0] core_fn(input int mode, input logic [63:0] x);
    logic [31:0] l, r, t;
    if (mode == 0) return x ^ 64'hDEADBEEF01234567;
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 8; i++) begin
      t = r;
      r = l ^ ((r * 32'h9E3779B1) ^ (r >> 11) ^ (32'(i) * 32'h7F4A7C15));
      l = t;
    end
    return {r, l};
  endfunction

  // Buffer after n encryptions applied in block order 0,1,2,0,1,2,...
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] init, input int mode, input int n);
    logic [63:0]  blocks [NB];
    logic [W-1:0] out;
    for (int b = 0; b < NB; b++) blocks[b] = init[64*(NB-b)-1 -: 64];
    for (int i = 0; i < n; i++) blocks[i % NB] = core_fn(mode, blocks[i % NB]);
    for (int b = 0; b < NB; b++) out[64*(NB-b)-1 -: 64] = blocks[b];
    return out;
  endfunction

  int          core_mode = 0;
  int          lat_lo = 1, lat_hi = 1, stall_lo = 0, stall_hi = 0;
  bit          outstanding = 0;
  int          cnt = 0;
  int          stall_left = 0;
  int          req_count = 0;
  int          res_count = 0;
  logic [63:0] held;
  bit          prev_waiting = 0;
  logic [31:0] prev_l, prev_r;

  // Core model: all decisions made on the falling edge, sampled by the DUT on the next rising edge.
  initial begin
    enc_ready = 1'b0;
    res_valid = 1'b0;
    res_l     = '0;
    res_r     = '0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (outstanding) begin
        cnt--;
        if (cnt == 0) begin
          {res_l, res_r} = core_fn(core_mode, held);
          res_valid   = 1'b1;
          outstanding = 1'b0;
          res_count++;
        end
      end
      if (prev_waiting && rst_n && !abort) begin
        chk("valid_held", enc_valid, 1);
        chk("hold_l", enc_l, prev_l);
        chk("hold_r", enc_r, prev_r);
      end
      if (enc_valid) begin
        if (stall_left > 0) begin
          enc_ready = 1'b0;
          stall_left--;
        end else begin
          enc_ready = 1'b1;
        end
      end else begin
        enc_ready = 1'b0;
      end
      prev_waiting = enc_valid && !enc_ready;
      prev_l = enc_l;
      prev_r = enc_r;
      if (enc_valid && enc_ready) begin
        chk("one_outstanding", outstanding, 0);
        outstanding = 1'b1;
        held        = {enc_l, enc_r};
        cnt         = $urandom_range(lat_hi, lat_lo);
        stall_left  = $urandom_range(stall_hi, stall_lo);
        req_count++;
      end
    end
  end

  function automatic logic [W-1:0] rand_ctext();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_job(input logic [W-1:0] init, input string name, input int exp_cycles,
                         input int mid_start_at, input bit check_one);
    int           k, req0, done1_at;
    bit           got_done;
    logic [W-1:0] exp;
    exp  = ref_model(init, core_mode, NB * NP);
    req0 = req_count;
    @(negedge clk); #1;
    ctext_in = init;
    start    = 1'b1;
    @(negedge clk); #1;
    start    = 1'b0;
    ctext_in = ~init;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_valid"}, enc_valid, 1);
    chk({name, "_first_req"}, {enc_l, enc_r}, init[W-1 -: 64]);
    if (check_one) begin
      chk("p1_valid", enc_valid1, 1);
      chk("p1_first_req", {enc_l1, enc_r1}, init[W-1 -: 64]);
    end
    k = 1;
    got_done = 1'b0;
    done1_at = 0;
    while (!got_done && k < 20000) begin
      if (done1 && done1_at == 0) done1_at = k + 1;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (k == mid_start_at) begin
          ctext_in = rand_ctext();
          start    = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    chk({name, "_done_seen"}, got_done, 1);
    if (exp_cycles > 0) chk({name, "_cycles"}, k + 1, exp_cycles);
    chk({name, "_busy_at_done"}, busy, 0);
    chk({name, "_ctext"}, ctext_out, exp);
    chk({name, "_reqs"}, req_count - req0, NB * NP);
    if (check_one) begin
      chk("p1_cycles", done1_at, 8);
      chk("p1_ctext", ctext_out1, ref_model(init, 0, NB));
      chk("p1_busy", busy1, 0);
    end
    @(negedge clk); #1;
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_idle_valid"}, enc_valid, 0);
  endtask

  task automatic abort_job(input logic [W-1:0] init, input int after_res, output logic [W-1:0] exp_buf);
    int res0, k_done, guard, dones, reqs;
    res0 = res_count;
    @(negedge clk); #1;
    ctext_in = init;
    start    = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!((res_count - res0) >= after_res && outstanding && cnt > 0 && cnt < lat_hi)
           && guard < 5000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("abort_reached_wait", guard < 5000, 1);
    abort  = 1'b1;
    k_done = res_count - res0;
    @(negedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", enc_valid, 0);
    dones = 0;
    reqs  = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      if (enc_valid) reqs++;
      @(negedge clk); #1;
    end
    chk("abort_late_res_sent", res_count - res0, k_done + 1);
    chk("abort_no_done", dones, 0);
    chk("abort_no_req", reqs, 0);
    exp_buf = ref_model(init, core_mode, k_done);
    chk("abort_buf", ctext_out, exp_buf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] init, exp_buf;
    rst_n    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    ctext_in = 192'h00112233445566778899AABBCCDDEEFF0123456789ABCDEF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", enc_valid, 0);
    chk("rst_ctext", ctext_out, 0);
    chk("rst_enc", {enc_l, enc_r}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", busy, 0);

    // XOR core, full rate; single-pass instance finishes at cycle 8.
    core_mode = 0;
    run_job(192'h00112233445566778899AABBCCDDEEFF0123456789ABCDEF, "xor", 386, -1, 1'b1);

    core_mode = 1;
    run_job(BCRYPT_CTEXT_INIT, "magic", 386, -1, 1'b0);

    // Every request stalled for 5 cycles.
    stall_lo   = 5;
    stall_hi   = 5;
    stall_left = 5;
    run_job(BCRYPT_CTEXT_INIT, "stall5", 386 + 5 * NB * NP, -1, 1'b0);

    // Random latency and backpressure with a start pulse mid-job.
    lat_lo   = 1;
    lat_hi   = 4;
    stall_lo = 0;
    stall_hi = 3;
    run_job(rand_ctext(), "rand_mid_start", -1, 50, 1'b0);

    lat_lo   = 3;
    lat_hi   = 3;
    stall_hi = 2;
    init = rand_ctext();
    abort_job(init, $urandom_range(30, 2), exp_buf);

    // start and abort together in IDLE: nothing happens.
    @(negedge clk); #1;
    ctext_in = rand_ctext();
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_busy", busy, 0);
      chk("start_abort_valid", enc_valid, 0);
      @(negedge clk); #1;
    end
    chk("start_abort_buf", ctext_out, exp_buf);

    lat_lo   = 1;
    lat_hi   = 2;
    stall_hi = 2;
    run_job(rand_ctext(), "after_abort", -1, -1, 1'b0);

    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst2_ctext", ctext_out, 0);
    chk("rst2_busy", busy, 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
